// File: rtl/spi_master.sv
// SPI initiator: accepts a one-cycle request, shifts a 16-bit {addr, rw, data} frame
// MSB-first with generated sclk/cs_n, and returns the 8 read-data bits with a done pulse.
module spi_master #(
    parameter int HALF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       miso,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);
    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   frame_q, frame_d;
    logic          rw_q, rw_d;
    logic [7:0]    cap_q, cap_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    rdata_q, rdata_d;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        rw_d    = rw_q;
        cap_d   = cap_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    frame_d = {addr, rw, (rw ? 8'h00 : wdata)};
                    rw_d    = rw;
                    hcnt_d  = '0;
                    bit_d   = 4'd0;
                    sclk_d  = 1'b0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = addr[6];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (hcnt_q == HLAST) begin
                    hcnt_d = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: only the data-phase bits of a read are captured.
                        if (rw_q && bit_q[3]) begin
                            cap_d = {cap_q[6:0], miso};
                        end else begin
                            cap_d = cap_q;
                        end
                    end else if (bit_q == 4'd15) begin
                        state_d = S_HOLD;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        frame_d = {frame_q[14:0], 1'b0};
                        mosi_d  = frame_q[14];
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_HOLD: begin
                if (hcnt_q == HLAST) begin
                    state_d = S_IDLE;
                    hcnt_d  = '0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    if (rw_q) begin
                        rdata_d = cap_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the idle bus and clears rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            bit_q   <= 4'd0;
            frame_q <= 16'h0000;
            rw_q    <= 1'b0;
            cap_q   <= 8'h00;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            rw_q    <= rw_d;
            cap_q   <= cap_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign sclk  = sclk_q;
    assign cs_n  = cs_n_q;
    assign mosi  = mosi_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator for the SPI-memory lab system; drives the serial bus that the peripheral-side shift register and FSM respond to.
- Accepts a one-cycle transaction request: 7-bit address, R/W flag, and 8-bit write data.
- Serialises a 16-bit frame (address, R/W, data) MSB-first and generates the chip-select and serial clock.
- On reads, captures the 8 returned data bits and presents them in parallel with a one-cycle done pulse.

Parameters:
- HALF, 4, serial-clock half-period in clk cycles; legal values are 1 or greater.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  transaction request; sampled only while busy=0.
- rw  input  1  1=read, 0=write; latched at accept.
- addr  input  7  target address; latched at accept.
- wdata  input  8  write data; latched at accept.
- miso  input  1  serial data from the peripheral.
- sclk  output  1  serial clock; idles low.
- cs_n  output  1  active-low chip select; idles high.
- mosi  output  1  serial data to the peripheral.
- busy  output  1  high from the accept edge until the done edge.
- done  output  1  one-cycle pulse at the end of a frame.
- rdata  output  8  last read result.

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, done=0, rdata=0x00.
- All outputs are registered.
- Reset wins over every other event. Asserting reset mid-frame aborts the frame:
  - the next edge forces the idle values above;
  - no done pulse is produced;
  - rdata returns to 0.
- States:
  - IDLE: start=1 moves to SHIFT. Latch {addr, rw, wdata} into a 16-bit frame register F = {addr[6:0], rw, rw ? 8'h00 : wdata}. Call this accept edge E0.
  - SHIFT: 16 sclk periods, driven by a half-period counter (0..HALF-1) and a bit counter (0..15).
  - HOLD: HALF cycles with sclk low and cs_n low.
  - Return to IDLE with done=1.
- Timing relative to E0:
  - At E0: cs_n goes 0, busy goes 1, and mosi takes F[15].
  - Rising sclk edge of bit n (n=0..15) occurs at E0+(2n+1)·HALF.
  - Falling sclk edge of bit n occurs at E0+(2n+2)·HALF. At each falling edge with n<15, mosi shifts to the next bit, F[14-n].
  - After the last falling edge (E0+32·HALF), sclk stays low for HALF cycles.
  - At E0+33·HALF: cs_n goes 1, busy goes 0, done goes 1 for one cycle, and mosi goes 0.
- Sampling: on the clk edge that raises sclk for bits 8..15, the value of miso present before that edge is shifted into an 8-bit capture register, MSB first. The peripheral changes miso on falling sclk edges.
- rdata:
  - Read frame: rdata loads the capture register at the done edge.
  - Write frame: rdata is unchanged; miso is ignored for the whole frame.
- mosi during the data phase of a read is 0.
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - addr, rw and wdata may change after E0 without affecting the frame.
  - Back-to-back: start=1 sampled at the edge after the done edge, while done=1 is visible, is accepted. The new E0 is that edge, giving a minimum gap of one cycle with cs_n high.
- HALF=1: sclk toggles every clk cycle. The timing equations above still hold.
- Frame length is fixed at 16 bits.

Test Plan:
- Reset → sclk=0, cs_n=1, mosi=0, busy=0, done=0, rdata=0x00. Hold reset mid-frame at E0+10 → idle values on the next edge and no done pulse.
- HALF=2, write addr=0x15, wdata=0xA5 → rising-edge mosi samples 0,0,1,0,1,0,1, then 0, then 1,0,1,0,0,1,0,1.
  - First rising sclk at E0+2, last falling at E0+64.
  - done pulse at E0+66; rdata stays 0x00.
- HALF=2, read addr=0x7F with a peripheral model driving 0x3C on falling edges of bits 7..14:
  - rw bit (bit 7) = 1;
  - data-phase mosi = 0;
  - rdata=0x3C at the done edge.
- start pulsed at E0+5 and E0+40 during an active frame → ignored; a single frame; exactly 16 rising sclk edges.
- Back-to-back: hold start=1 continuously through two frames → the second E0 falls one cycle after the first done edge, and cs_n is high for exactly one cycle between frames.
- HALF=1, read returning 0x81 → first rising sclk at E0+1, done at E0+33, rdata=0x81.
